// File: rtl/gaus_read_scheduler.sv
// Gaussian smoothing read scheduler.
// For each column word it issues five SRAM1 row reads, one row stride apart,
// walking up from the bottom row of the 5-row window. It then pulses the
// pop/shift/hold/mult/norm enables so that each one lines up with the returned
// data. A PIPE_LAT-deep delay line of shift_en produces out_en.
module gaus_read_scheduler #(
  parameter int ADDR_W     = 20,
  parameter int ROW_WORDS  = 256,
  parameter int START_ADDR = 1024,
  parameter int END_ADDR   = 523518,
  parameter int PIPE_LAT   = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              pop_en,
  output logic              shift_en,
  output logic              hold_en,
  output logic              mult_en,
  output logic              norm_en,
  output logic              out_en,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_PAUSED, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [2:0]          phase_q, phase_d;   // phase of the address currently on rd_addr
  logic [ADDR_W-1:0]   col_q, col_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                pop_q, pop_d;
  logic                shift_q, shift_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PIPE_LAT-1:0] dly_q, dly_d;       // dly_q[i] = shift_en delayed by i+1 cycles

  // Pulses still in flight: shift_en plus every delay tap except the final
  // one, which is the out_en being presented this cycle.
  logic [PIPE_LAT:0]   line;
  logic                pending;
  assign line    = {dly_q, shift_q};
  assign pending = |line[PIPE_LAT-1:0];

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      phase_q   <= 3'd0;
      col_q     <= START_A;
      rd_addr_q <= START_A;
      rd_en_q   <= 1'b0;
      pop_q     <= 1'b0;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      col_q     <= col_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      pop_q     <= pop_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dly_q     <= dly_d;
    end
  end

  // Next-state logic; pause and the end check only apply at the phase-4 read.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_ISSUE;
      S_ISSUE:  if (phase_q == 3'd4) begin
                  if (col_q == END_A) state_d = S_DRAIN;
                  else if (pause)     state_d = S_PAUSED;
                end
      S_PAUSED: if (!pause) state_d = S_ISSUE;
      S_DRAIN:  if (!pending) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; all outputs leave through registers.
  always_comb begin
    rd_addr_d = rd_addr_q;
    col_d     = col_q;
    phase_d   = phase_q;
    rd_en_d   = 1'b0;
    pop_d     = 1'b0;
    shift_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dly_d     = line[PIPE_LAT-1:0];
    unique case (state_q)
      S_IDLE: if (start) begin
        rd_addr_d = START_A;
        col_d     = START_A;
        phase_d   = 3'd0;
        rd_en_d   = 1'b1;
        busy_d    = 1'b1;
      end
      S_ISSUE: if (phase_q != 3'd4) begin
        // Next row up; wraps modulo 2^ADDR_W by design.
        rd_addr_d = rd_addr_q - STRIDE;
        phase_d   = phase_q + 3'd1;
        rd_en_d   = 1'b1;
        pop_d     = 1'b1;
      end else begin
        shift_d = 1'b1;
        col_d   = col_q + ADDR_W'(1);
        if (state_d == S_ISSUE) begin
          rd_addr_d = col_q + ADDR_W'(1);
          phase_d   = 3'd0;
          rd_en_d   = 1'b1;
        end
      end
      // col_q already points at the next group; rd_addr holds until resume.
      S_PAUSED: if (!pause) begin
        rd_addr_d = col_q;
        phase_d   = 3'd0;
        rd_en_d   = 1'b1;
      end
      S_DRAIN: if (!pending) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_addr  = rd_addr_q;
  assign rd_en    = rd_en_q;
  assign pop_en   = pop_q;
  assign shift_en = shift_q;
  assign hold_en  = shift_q;
  assign mult_en  = shift_q;
  assign norm_en  = shift_q;
  assign out_en   = dly_q[PIPE_LAT-1];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_gaus_read_scheduler.sv
// Bench for gaus_read_scheduler: directed scenarios plus random start/pause/reset
// traffic, checked every cycle against a transaction-level read-list model.
module tb_gaus_read_scheduler;

  localparam int M_START = 1024;
  localparam int M_END   = 1026;
  localparam int M_N     = M_END - M_START + 1;
  localparam int RW      = 256;
  localparam int PL      = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, start = 1'b0, pause = 1'b0;
  logic [19:0] rd_addr;
  logic rd_en, pop_en, shift_en, hold_en, mult_en, norm_en, out_en, busy, done;

  gaus_read_scheduler #(.ADDR_W(20), .ROW_WORDS(RW), .START_ADDR(M_START),
                        .END_ADDR(M_END), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(rst_n), .start(start), .pause(pause),
    .rd_addr(rd_addr), .rd_en(rd_en), .pop_en(pop_en), .shift_en(shift_en),
    .hold_en(hold_en), .mult_en(mult_en), .norm_en(norm_en), .out_en(out_en),
    .busy(busy), .done(done));

  // Auxiliary instances for single-group and wrap-around checks.
  logic a_rst = 1'b0, a_start = 1'b0, a_pause = 1'b0;
  logic [19:0] s_addr;
  logic [11:0] w_addr, v_addr;
  logic s_en, s_pop, s_sh, s_ho, s_mu, s_no, s_out, s_busy, s_done;
  logic w_en, w_pop, w_sh, w_ho, w_mu, w_no, w_out, w_busy, w_done;
  logic v_en, v_pop, v_sh, v_ho, v_mu, v_no, v_out, v_busy, v_done;

  gaus_read_scheduler #(.ADDR_W(20), .ROW_WORDS(256), .START_ADDR(1024),
                        .END_ADDR(1024), .PIPE_LAT(14)) u_single (
    .clk(clk), .reset(a_rst), .start(a_start), .pause(a_pause),
    .rd_addr(s_addr), .rd_en(s_en), .pop_en(s_pop), .shift_en(s_sh),
    .hold_en(s_ho), .mult_en(s_mu), .norm_en(s_no), .out_en(s_out),
    .busy(s_busy), .done(s_done));

  gaus_read_scheduler #(.ADDR_W(12), .ROW_WORDS(256), .START_ADDR(4095),
                        .END_ADDR(4095), .PIPE_LAT(14)) u_wrap (
    .clk(clk), .reset(a_rst), .start(a_start), .pause(a_pause),
    .rd_addr(w_addr), .rd_en(w_en), .pop_en(w_pop), .shift_en(w_sh),
    .hold_en(w_ho), .mult_en(w_mu), .norm_en(w_no), .out_en(w_out),
    .busy(w_busy), .done(w_done));

  gaus_read_scheduler #(.ADDR_W(12), .ROW_WORDS(256), .START_ADDR(1023),
                        .END_ADDR(1023), .PIPE_LAT(14)) u_wrap2 (
    .clk(clk), .reset(a_rst), .start(a_start), .pause(a_pause),
    .rd_addr(v_addr), .rd_en(v_en), .pop_en(v_pop), .shift_en(v_sh),
    .hold_en(v_ho), .mult_en(v_mu), .norm_en(v_no), .out_en(v_out),
    .busy(v_busy), .done(v_done));

  int checks = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is a list of reads still to issue; the enables
  // follow from what was issued the previous cycle, out_en from a schedule.
  logic [19:0] rq_a[$];
  int          rq_k[$];
  int          outq[$];
  int          cyc = 0, outs_left = 0;
  bit          m_busy = 0, m_paused = 0;
  logic [19:0] e_addr = 20'(M_START);
  int          e_k = 0;
  bit e_rd_en = 0, e_pop = 0, e_shift = 0, e_out = 0, e_busy = 0, e_done = 0;

  task automatic issue();
    e_addr  = rq_a.pop_front();
    e_k     = rq_k.pop_front();
    e_rd_en = 1;
  endtask

  task automatic model_step(input bit r, input bit s, input bit p);
    bit pr_en, pout;
    int pk;
    cyc++;
    if (!r) begin
      rq_a.delete(); rq_k.delete(); outq.delete();
      m_busy = 0; m_paused = 0; outs_left = 0;
      e_addr = 20'(M_START); e_k = 0;
      e_rd_en = 0; e_pop = 0; e_shift = 0; e_out = 0; e_busy = 0; e_done = 0;
      return;
    end
    pr_en = e_rd_en; pk = e_k; pout = e_out;
    e_pop   = pr_en && pk < 4;
    e_shift = pr_en && pk == 4;
    if (e_shift) outq.push_back(cyc + PL);
    e_out = (outq.size() > 0) && (outq[0] == cyc);
    if (e_out) begin void'(outq.pop_front()); outs_left--; end
    e_done  = m_busy && pout && outs_left == 0;
    e_rd_en = 0;
    if (e_done) m_busy = 0;
    else if (!m_busy) begin
      if (s) begin
        for (int g = 0; g < M_N; g++)
          for (int k = 0; k < 5; k++) begin
            rq_a.push_back(20'(M_START + g) - 20'(k * RW));
            rq_k.push_back(k);
          end
        m_busy = 1; m_paused = 0; outs_left = M_N;
        issue();
      end
    end else if (m_paused) begin
      if (!p) begin m_paused = 0; issue(); end
    end else if (rq_a.size() > 0) begin
      if (pr_en && pk == 4 && p) m_paused = 1;
      else issue();
    end
    e_busy = m_busy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst_n, start, pause);
    #1;
    check("rd_en",    32'(rd_en),    32'(e_rd_en));
    check("rd_addr",  32'(rd_addr),  32'(e_addr));
    check("pop_en",   32'(pop_en),   32'(e_pop));
    check("shift_en", 32'(shift_en), 32'(e_shift));
    check("hold_en",  32'(hold_en),  32'(e_shift));
    check("mult_en",  32'(mult_en),  32'(e_shift));
    check("norm_en",  32'(norm_en),  32'(e_shift));
    check("out_en",   32'(out_en),   32'(e_out));
    check("busy",     32'(busy),     32'(e_busy));
    check("done",     32'(done),     32'(e_done));
  endtask

  initial begin
    int n_out, n_done;
    // Reset state
    rst_n = 0; tick(); tick();
    check("rst_addr", 32'(rd_addr), 32'd1024);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1; tick();

    // Scenario 1: basic run
    start = 1; tick(); start = 0;
    n_out = 0; n_done = 0;
    for (int c = 1; c <= 35; c++) begin
      if (c == 5)  check("s1_addr_c5", 32'(rd_addr), 32'd0);
      if (c == 15) check("s1_addr_c15", 32'(rd_addr), 32'd2);
      if (c == 16) check("s1_shift_c16", 32'(shift_en), 32'd1);
      if (c == 20) check("s1_out_c20", 32'(out_en), 32'd1);
      if (c == 30) check("s1_busy_c30", 32'(busy), 32'd1);
      if (c == 31) check("s1_done_c31", 32'(done), 32'd1);
      if (c == 31) check("s1_busy_c31", 32'(busy), 32'd0);
      n_out += int'(out_en); n_done += int'(done);
      tick();
    end
    check("s1_outs", n_out, 3);
    check("s1_dones", n_done, 1);

    // Scenario 2: pause during cycles 4-9
    start = 1; tick(); start = 0;
    n_out = 0; n_done = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 8)  check("s2_rden_c8", 32'(rd_en), 32'd0);
      if (c == 11) check("s2_addr_c11", 32'(rd_addr), 32'd1025);
      if (c == 11) check("s2_rden_c11", 32'(rd_en), 32'd1);
      if (c == 20) check("s2_out_c20", 32'(out_en), 32'd1);
      n_out += int'(out_en); n_done += int'(done);
      pause = (c >= 4 && c <= 9);
      tick();
    end
    pause = 0;
    check("s2_outs", n_out, 3);
    check("s2_dones", n_done, 1);

    // Scenario 3: start while busy at cycle 8
    start = 1; tick(); start = 0;
    n_out = 0;
    for (int c = 1; c <= 35; c++) begin
      if (c == 31) check("s3_done_c31", 32'(done), 32'd1);
      n_out += int'(out_en);
      start = (c == 8);
      tick();
    end
    start = 0;
    check("s3_outs", n_out, 3);

    // Scenario 4: reset mid-frame at cycle 9, then a fresh frame
    start = 1; tick(); start = 0;
    n_out = 0; n_done = 0;
    for (int c = 1; c <= 35; c++) begin
      if (c == 10) check("s4_addr_c10", 32'(rd_addr), 32'd1024);
      if (c == 10) check("s4_busy_c10", 32'(busy), 32'd0);
      if (c >= 10) begin n_out += int'(out_en); n_done += int'(done); end
      rst_n = (c != 9);
      tick();
    end
    rst_n = 1;
    check("s4_no_out", n_out, 0);
    check("s4_no_done", n_done, 0);
    start = 1; tick(); start = 0;
    for (int c = 1; c <= 35; c++) begin
      if (c == 31) check("s4_rerun_done", 32'(done), 32'd1);
      tick();
    end

    // Scenarios 5 and 6: single group and address wrap
    a_rst = 1; tick();
    a_start = 1; tick(); a_start = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c <= 5) begin
        check("s5_addr", 32'(s_addr), 32'(1024 - 256 * (c - 1)));
        check("s6_wrap_addr", 32'(w_addr), 32'((4095 - 256 * (c - 1)) & 32'hFFF));
        check("s6_wrap2_addr", 32'(v_addr), 32'((1023 - 256 * (c - 1)) & 32'hFFF));
      end
      check("s5_rden", 32'(s_en), 32'(c <= 5));
      check("s5_shift", 32'(s_sh), 32'(c == 6));
      check("s5_out", 32'(s_out), 32'(c == 20));
      check("s5_done", 32'(s_done), 32'(c == 21));
      check("s5_busy", 32'(s_busy), 32'(c <= 20));
      tick();
    end

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) pause = ~pause;
      rst_n = !($urandom_range(0, 299) == 0);
      tick();
    end
    rst_n = 1; start = 0; pause = 0;
    for (int i = 0; i < 60; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
